ofs_plat_prim_af_reg_pipe: RTL and testbench
============================================

// Module: ofs_plat_prim_af_reg_pipe
//
// PURPOSE
// - Single-channel ready/enable register pipeline. Forward path: N_REG_STAGES registers.
//   Return path: ready runs through N_READY_STAGES registers as an almost-full credit signal.
// - Unlike a bare almost-full pipe, it ends in an internal slack FIFO. The sink therefore sees
//   standard ready/enable and needs no slack guarantee of its own.
// - Building block for AXI/Avalon reg wrappers: one instance per request channel (AW, W, AR).
//
// PARAMETERS
// - N_DATA_BITS     64                 payload width per beat
// - N_REG_STAGES    1                  forward register stages (0 = source wired to FIFO write)
// - N_READY_STAGES  N_REG_STAGES       ready_to_src delay stages (0 = combinational ready)
// - FIFO_DEPTH      2*(N_REG_STAGES+N_READY_STAGES+1)
//                                      slack FIFO entries; elaboration error if < SLACK+1
//
// PORTS
// - clk               in   1            single clock for all logic
// - reset_n           in   1            asynchronous, active-low reset
// - enable_from_src   in   1            source beat valid
// - data_from_src     in   N_DATA_BITS  source payload
// - ready_to_src      out  1            almost-full credit; a beat is accepted only when enable & ready
// - enable_to_dst     out  1            FIFO head valid (standard valid)
// - data_to_dst       out  N_DATA_BITS  FIFO head payload
// - ready_from_dst    in   1            sink ready (standard; may drop at any time)
// - overflow_err      out  1            sticky; write attempted into a full FIFO (must never happen)
//
// BEHAVIOUR
// - localparam SLACK = N_REG_STAGES + N_READY_STAGES + 1.
// - Reset (async assert): values while reset_n is low:
//   - ready_to_src = 0, enable_to_dst = 0, overflow_err = 0.
//   - All stage valids, FIFO pointers/count and the ready shift register clear.
//   - Payload registers and FIFO memory are not reset.
// - Accept: acc = enable_from_src & ready_to_src.
//   - enable while ready=0 is ignored; the source must hold the beat.
// - Forward stage s (1..N) registers {valid, data} from stage s-1 every cycle, with no stall.
//   - Stage 0 = {acc, data_from_src}.
//   - Stage N_REG_STAGES valid is the FIFO write enable.
// - FIFO:
//   - Write = last-stage valid. Read = enable_to_dst & ready_from_dst.
//   - Pointers wrap FIFO_DEPTH-1 -> 0 (depth need not be a power of 2).
//   - count is $clog2(FIFO_DEPTH+1) bits.
//   - Simultaneous read & write leaves count unchanged, including when count is FIFO_DEPTH.
//   - Write while full and not reading: set overflow_err, drop the beat. Simulation $error.
// - Output is first-word-fall-through from registered storage:
//   - enable_to_dst = (count != 0); data_to_dst = mem[rd_ptr].
//   - A beat written at cycle t is visible at t+1.
// - Credit:
//   - ready_raw = (count <= FIFO_DEPTH - SLACK), from the current registered count.
//   - ready_to_src = ready_raw delayed N_READY_STAGES cycles.
//   - Shift-register bits load 0 while in reset.
//   - This guarantees no overflow for any sink ready pattern.
// - Latency: a beat accepted at t reaches enable_to_dst at t + N_REG_STAGES + 1 when the FIFO is empty.
// - Throughput: 1 beat/clk sustained while ready_from_dst = 1.
// - After reset release: ready_to_src rises N_READY_STAGES cycles later (the cycle after release when 0).
// - Mid-operation reset: every in-flight and buffered beat is discarded; no partial output.
//
// STRUCTURE
// - ofs_plat_prim_pkg gains function af_pipe_slack(n_reg, n_ready) returning SLACK, so wrappers
//   size FIFOs identically. No new typedefs.
// - Sub-module ofs_plat_prim_af_slack_fifo: FWFT FIFO with count, full and overflow flag.
//   - Ports: clk, reset_n, wr_en/wr_data, rd_en/rd_data/rd_valid, count, overflow.
// - Top: forward stage generate loop, ready shift register, credit compare, FIFO instance.
//
// TESTING
// - Reset: hold reset_n=0 with enable_from_src=1 -> ready_to_src=0, enable_to_dst=0.
//   - After release, ready_to_src=1 exactly N_READY_STAGES clks later.
// - Streaming (N_REG=2, N_READY=2, depth 10): 100 beats of incrementing data, ready_from_dst=1.
//   - Output matches in order, first beat at t+3, 1 beat/clk, count never exceeds 5.
// - Back-pressure: ready_from_dst=0 while the source pushes.
//   - ready_to_src drops once count > 5. FIFO peaks at <=10 entries. overflow_err stays 0.
//   - Release ready: all beats drain in order.
// - Random sweep: N_REG 0..3, N_READY 0..3, random enable/ready at 50%, 10k beats.
//   - Scoreboard exact match; overflow_err=0.
// - Wrap/simultaneous: non-power-of-2 depth 7, FIFO held full with read & write every clk for 50 clks.
//   - count stays 7; data is correct across pointer wrap.
// - Mid-stream reset: assert reset_n with 4 beats in flight.
//   - Outputs clear asynchronously; none of the 4 beats appears after release.

Source files
------------

// File: rtl/ofs_plat_prim_pkg.sv
// Shared helpers for the platform primitive library.
package ofs_plat_prim_pkg;

  // Beats that can still arrive after credit drops: forward stages, ready
  // delay stages and the cycle of the compare itself.
  function automatic int af_pipe_slack(input int n_reg, input int n_ready);
    return n_reg + n_ready + 1;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_af_slack_fifo.sv
// First-word-fall-through FIFO with occupancy count and sticky overflow flag.
// Depth need not be a power of two.
module ofs_plat_prim_af_slack_fifo #(
  parameter int N_DATA_BITS = 64,
  parameter int FIFO_DEPTH  = 4,
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [N_DATA_BITS-1:0] wr_data,
  input  logic                   rd_en,
  output logic [N_DATA_BITS-1:0] rd_data,
  output logic                   rd_valid,
  output logic [CNT_BITS-1:0]    count,
  output logic                   overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic                   full, rd_fire, wr_fire;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign full     = (count == CNT_BITS'(FIFO_DEPTH));
  assign rd_fire  = rd_en & rd_valid;
  // A full FIFO still takes a write in the same cycle its head is read.
  assign wr_fire  = wr_en & (~full | rd_fire);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= next_ptr(wr_ptr);
      if (rd_fire) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_fire) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en && !wr_fire)
      $error("ofs_plat_prim_af_slack_fifo: write into full FIFO, beat dropped");
  end

endmodule

// File: rtl/ofs_plat_prim_af_reg_pipe.sv
// Registered forward path with almost-full credit return, terminated in a
// slack FIFO so the sink sees plain ready/enable.
module ofs_plat_prim_af_reg_pipe
  import ofs_plat_prim_pkg::*;
#(
  parameter int N_DATA_BITS    = 64,
  parameter int N_REG_STAGES   = 1,
  parameter int N_READY_STAGES = N_REG_STAGES,
  parameter int FIFO_DEPTH     = 2 * (N_REG_STAGES + N_READY_STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_from_src,
  input  logic [N_DATA_BITS-1:0] data_from_src,
  output logic                   ready_to_src,
  output logic                   enable_to_dst,
  output logic [N_DATA_BITS-1:0] data_to_dst,
  input  logic                   ready_from_dst,
  output logic                   overflow_err
);

  localparam int SLACK    = af_pipe_slack(N_REG_STAGES, N_READY_STAGES);
  localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < SLACK + 1) begin : g_depth_chk
    $error("ofs_plat_prim_af_reg_pipe: FIFO_DEPTH smaller than credit slack + 1");
  end

  logic [N_REG_STAGES:0]                  vld_pipe;
  logic [N_REG_STAGES:0][N_DATA_BITS-1:0] data_pipe;
  logic [N_READY_STAGES:0]                rdy_pipe;
  logic [CNT_BITS-1:0]                    fifo_count;
  logic                                   ready_raw;

  assign vld_pipe[0]  = enable_from_src & ready_to_src;
  assign data_pipe[0] = data_from_src;

  if (N_REG_STAGES > 0) begin : g_fwd
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_pipe[N_REG_STAGES:1] <= '0;
      else          vld_pipe[N_REG_STAGES:1] <= vld_pipe[N_REG_STAGES-1:0];
    end

    always_ff @(posedge clk) begin
      data_pipe[N_REG_STAGES:1] <= data_pipe[N_REG_STAGES-1:0];
    end
  end

  // Credit is granted while the FIFO can still absorb every beat already
  // committed upstream of the compare.
  assign ready_raw   = (fifo_count <= CNT_BITS'(FIFO_DEPTH - SLACK));
  assign rdy_pipe[0] = ready_raw;

  if (N_READY_STAGES > 0) begin : g_rdy
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdy_pipe[N_READY_STAGES:1] <= '0;
      else          rdy_pipe[N_READY_STAGES:1] <= rdy_pipe[N_READY_STAGES-1:0];
    end
  end

  // Gating keeps the zero-delay configuration silent during reset.
  assign ready_to_src = rdy_pipe[N_READY_STAGES] & reset_n;

  ofs_plat_prim_af_slack_fifo #(
    .N_DATA_BITS (N_DATA_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (vld_pipe[N_REG_STAGES]),
    .wr_data  (data_pipe[N_REG_STAGES]),
    .rd_en    (ready_from_dst),
    .rd_data  (data_to_dst),
    .rd_valid (enable_to_dst),
    .count    (fifo_count),
    .overflow (overflow_err)
  );

endmodule

// File: tb/tb_ofs_plat_prim_af_reg_pipe.sv
// Directed bench: reset, streaming latency, back-pressure credit, mid-stream
// reset, random traffic on two pipe configurations and a depth-7 FIFO wrap run.
module tb_ofs_plat_prim_af_reg_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // A: 2 reg / 2 ready stages, depth 10.  B: 0 / 0, depth 2.
  logic        a_en, a_rdy, a_en_dst, a_rdy_dst, a_ovf;
  logic [15:0] a_d, a_d_dst;
  logic        b_en, b_rdy, b_en_dst, b_rdy_dst, b_ovf;
  logic [15:0] b_d, b_d_dst;
  logic        f_wr_en, f_rd_en, f_rd_valid, f_ovf;
  logic [15:0] f_wr_data, f_rd_data;
  logic [2:0]  f_count;

  ofs_plat_prim_af_reg_pipe #(.N_DATA_BITS(16), .N_REG_STAGES(2), .N_READY_STAGES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .enable_from_src(a_en), .data_from_src(a_d),
    .ready_to_src(a_rdy), .enable_to_dst(a_en_dst), .data_to_dst(a_d_dst),
    .ready_from_dst(a_rdy_dst), .overflow_err(a_ovf));

  ofs_plat_prim_af_reg_pipe #(.N_DATA_BITS(16), .N_REG_STAGES(0), .N_READY_STAGES(0)) u_b (
    .clk(clk), .reset_n(reset_n), .enable_from_src(b_en), .data_from_src(b_d),
    .ready_to_src(b_rdy), .enable_to_dst(b_en_dst), .data_to_dst(b_d_dst),
    .ready_from_dst(b_rdy_dst), .overflow_err(b_ovf));

  ofs_plat_prim_af_slack_fifo #(.N_DATA_BITS(16), .FIFO_DEPTH(7)) u_f (
    .clk(clk), .reset_n(reset_n), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .count(f_count), .overflow(f_ovf));

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] qa_d[$], qb_d[$], qf[$];
  int qa_t[$];
  int acc_a_cnt = 0, pop_a_cnt = 0, acc_b_cnt = 0, pop_b_cnt = 0, max_cnt_a = 0;
  bit lat_chk = 0, acc_a_now, acc_b_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score accepts/pops, then advance past posedge.
  task automatic tick();
    logic [15:0] e;
    int t;
    @(negedge clk);
    acc_a_now = a_en & a_rdy;
    if (acc_a_now) begin qa_d.push_back(a_d); qa_t.push_back(cyc); acc_a_cnt++; end
    if (a_en_dst & a_rdy_dst) begin
      chk("a_sb_nonempty", qa_d.size() != 0, 1);
      if (qa_d.size() != 0) begin
        e = qa_d.pop_front(); t = qa_t.pop_front();
        chk("a_data", a_d_dst, e);
        if (lat_chk) chk("a_latency", cyc - t, 3);
      end
      pop_a_cnt++;
    end
    if (int'(u_a.fifo_count) > max_cnt_a) max_cnt_a = int'(u_a.fifo_count);
    acc_b_now = b_en & b_rdy;
    if (acc_b_now) begin qb_d.push_back(b_d); acc_b_cnt++; end
    if (b_en_dst & b_rdy_dst) begin
      chk("b_sb_nonempty", qb_d.size() != 0, 1);
      if (qb_d.size() != 0) begin e = qb_d.pop_front(); chk("b_data", b_d_dst, e); end
      pop_b_cnt++;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    int base_acc, base_pop;
    logic [15:0] e;
    reset_n = 1'b0;
    a_en = 1'b1; a_d = '0; a_rdy_dst = 1'b0;
    b_en = 1'b1; b_d = '0; b_rdy_dst = 1'b0;
    f_wr_en = 1'b0; f_wr_data = '0; f_rd_en = 1'b0;

    // Reset held with source enabled
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_rdy, 0);
    chk("rst_a_en_dst", a_en_dst, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_ready", b_rdy, 0);
    chk("rst_b_en_dst", b_en_dst, 0);
    chk("rst_f_count", f_count, 0);
    @(posedge clk); #1;
    a_en = 1'b0; b_en = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rel_b_ready_now", b_rdy, 1);
    chk("rel_a_ready_0", a_rdy, 0);
    tick();
    chk("rel_a_ready_1", a_rdy, 0);
    tick();
    chk("rel_a_ready_2", a_rdy, 1);

    // Streaming: 100 beats, sink always ready
    lat_chk = 1; a_rdy_dst = 1'b1; a_en = 1'b1; max_cnt_a = 0;
    base_acc = acc_a_cnt; base_pop = pop_a_cnt;
    for (int i = 0; i < 100; i++) begin
      a_d = 16'(i);
      tick();
    end
    chk("stream_accepts", acc_a_cnt - base_acc, 100);
    a_en = 1'b0;
    repeat (6) tick();
    chk("stream_pops", pop_a_cnt - base_pop, 100);
    chk("stream_sb_empty", qa_d.size(), 0);
    chk("stream_max_cnt_le5", max_cnt_a <= 5, 1);
    lat_chk = 0;

    // Back-pressure: sink stalled, source pushes continuously
    a_rdy_dst = 1'b0; a_en = 1'b1; max_cnt_a = 0;
    base_acc = acc_a_cnt; base_pop = pop_a_cnt;
    for (int i = 0; i < 30; i++) begin
      a_d = 16'h0100 + 16'(acc_a_cnt - base_acc);
      tick();
    end
    chk("bp_accepts", acc_a_cnt - base_acc, 10);
    chk("bp_ready_low", a_rdy, 0);
    chk("bp_peak_cnt", max_cnt_a, 10);
    chk("bp_ovf", a_ovf, 0);
    chk("bp_en_dst", a_en_dst, 1);
    a_en = 1'b0; a_rdy_dst = 1'b1;
    repeat (12) tick();
    chk("bp_drain_pops", pop_a_cnt - base_pop, 10);
    chk("bp_sb_empty", qa_d.size(), 0);

    // Mid-stream reset with beats in flight
    a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_d = 16'h0200 + 16'(i);
      tick();
    end
    a_en = 1'b0;
    chk("mid_en_before_rst", a_en_dst, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_en_dst", a_en_dst, 0);
    chk("mid_rst_ready", a_rdy, 0);
    qa_d.delete(); qa_t.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base_pop = pop_a_cnt;
    repeat (12) tick();
    chk("mid_no_ghost", pop_a_cnt - base_pop, 0);
    chk("mid_ready_back", a_rdy, 1);

    // Random traffic on A and B
    base_acc = acc_b_cnt; base_pop = pop_b_cnt;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!a_en || acc_a_now) begin a_en = 1'($urandom % 2); a_d = 16'($urandom); end
      if (!b_en || acc_b_now) begin b_en = 1'($urandom % 2); b_d = 16'($urandom); end
      a_rdy_dst = 1'($urandom % 2);
      b_rdy_dst = 1'($urandom % 2);
    end
    a_en = 1'b0; b_en = 1'b0; a_rdy_dst = 1'b1; b_rdy_dst = 1'b1;
    repeat (20) tick();
    chk("rnd_a_sb_empty", qa_d.size(), 0);
    chk("rnd_b_sb_empty", qb_d.size(), 0);
    chk("rnd_b_traffic", (acc_b_cnt - base_acc) > 500, 1);
    chk("rnd_b_balance", pop_b_cnt - base_pop, acc_b_cnt - base_acc);
    chk("rnd_a_ovf", a_ovf, 0);
    chk("rnd_b_ovf", b_ovf, 0);

    // Depth-7 FIFO: fill, then read+write every clock across pointer wrap
    f_wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      f_wr_data = 16'h0300 + 16'(i);
      qf.push_back(f_wr_data);
      @(posedge clk); #1;
    end
    f_wr_en = 1'b0;
    chk("f_full_count", f_count, 7);
    chk("f_full_valid", f_rd_valid, 1);
    f_wr_en = 1'b1; f_rd_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      e = qf.pop_front();
      chk("f_wrap_data", f_rd_data, e);
      f_wr_data = 16'h0400 + 16'(i);
      qf.push_back(f_wr_data);
      @(posedge clk); #1;
      chk("f_wrap_count", f_count, 7);
    end
    f_wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e = qf.pop_front();
      chk("f_drain_data", f_rd_data, e);
      @(posedge clk); #1;
    end
    f_rd_en = 1'b0;
    chk("f_empty_count", f_count, 0);
    chk("f_empty_valid", f_rd_valid, 0);
    chk("f_ovf", f_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
